// File: rtl/noc_mux_pkg.sv
// Shared helpers for the NoC mux/demux family: width math, command codes, channel slicing.
// Used by mux_nx1_pipe_reg and, with MUX_NX1_RR_ARB_EN defined, rr_arbiter_nx1.
package noc_mux_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_INPUT  = 4;

   // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) res++;
      return res;
   endfunction

   // The first command code past the directed range requests round-robin arbitration.
   function automatic int rr_cmd_code(input int num_input);
      return num_input;
   endfunction

   // LSB position of channel k inside a flattened {ch[N-1], ..., ch[0]} bus.
   function automatic int ch_lsb(input int k, input int data_width);
      return k * data_width;
   endfunction

endpackage

// File: rtl/rr_arbiter_nx1.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
// Compiled only when MUX_NX1_RR_ARB_EN is defined.
`ifdef MUX_NX1_RR_ARB_EN
module rr_arbiter_nx1
   import noc_mux_pkg::*;
#(
   parameter int NUM_INPUT = DEFAULT_NUM_INPUT,
   parameter int IDX_W     = clog2(NUM_INPUT)
) (
   input  logic [NUM_INPUT-1:0] i_req,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic [IDX_W-1:0]     o_grant_idx,
   output logic                 o_grant_vld
);

   int idx;

   // NOTE: blocking '=' in always_comb so later loop iterations see the earlier
   // grant; every output gets a default first so no latch is inferred.
   always_comb begin
      o_grant_vld = 1'b0;
      o_grant_idx = '0;
      idx         = 0;
      for (int off = 1; off <= NUM_INPUT; off++) begin
         idx = (int'(i_ptr) + off) % NUM_INPUT;
         if (!o_grant_vld && i_req[idx]) begin
            o_grant_vld = 1'b1;
            o_grant_idx = IDX_W'(idx);
         end
      end
   end

endmodule
`endif

// File: rtl/mux_nx1_pipe_reg.sv
// N-to-1 valid/ready mux with one registered output stage and backpressure.
// Define MUX_NX1_RR_ARB_EN to make i_cmd==NUM_INPUT arbitrate round-robin among valid inputs.
module mux_nx1_pipe_reg
   import noc_mux_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int NUM_INPUT     = DEFAULT_NUM_INPUT,
   parameter int COMMAND_WIDTH = clog2(NUM_INPUT) + 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_INPUT-1:0]            i_valid,
   input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus,
   output logic [NUM_INPUT-1:0]            o_ready,
   output logic                            o_valid,
   output logic [DATA_WIDTH-1:0]           o_data_bus,
   input  logic                            i_ready,
   input  logic                            i_en,
   input  logic [COMMAND_WIDTH-1:0]        i_cmd
);

   localparam int IDX_W       = clog2(NUM_INPUT);
   localparam int CMD_RR_CODE = rr_cmd_code(NUM_INPUT);

   logic [DATA_WIDTH-1:0] ch_data [NUM_INPUT];
   logic [IDX_W-1:0]      sel;
   logic                  sel_vld;
   logic                  space;
   logic                  take;
   logic                  accept;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   for (genvar k = 0; k < NUM_INPUT; k++) begin : g_unpack
      assign ch_data[k] = i_data_bus[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
   end

`ifdef MUX_NX1_RR_ARB_EN
   logic             rr_mode;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_vld;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   rr_arbiter_nx1 #(
      .NUM_INPUT (NUM_INPUT),
      .IDX_W     (IDX_W)
   ) u_rr_arbiter (
      .i_req       (i_valid),
      .i_ptr       (ptr_q),
      .o_grant_idx (grant_idx),
      .o_grant_vld (grant_vld)
   );

   assign rr_mode = (i_cmd == COMMAND_WIDTH'(CMD_RR_CODE));
`endif

   // Directed codes lie below the RR code; everything at or above it is "no source"
   // unless round-robin support overrides the RR code itself.
   always_comb begin
      sel     = i_cmd[IDX_W-1:0];
      sel_vld = (i_cmd < COMMAND_WIDTH'(CMD_RR_CODE));
`ifdef MUX_NX1_RR_ARB_EN
      if (rr_mode) begin
         sel     = grant_idx;
         sel_vld = grant_vld;
      end
`endif
   end

   assign space  = !valid_q || i_ready;
   // rst_n gates ready so nothing is offered while the output stage is held in reset.
   assign take   = rst_n && i_en && space && sel_vld;
   assign accept = take && i_valid[sel];

   always_comb begin
      o_ready = '0;
      for (int k = 0; k < NUM_INPUT; k++) o_ready[k] = take && (sel == IDX_W'(k));
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = ch_data[sel];
      end else if (i_ready) begin
         valid_d = 1'b0;
         data_d  = '0;
      end
   end

   // NOTE: non-blocking '<=' for all state; the data register is reset too
   // because o_data_bus must read zero whenever o_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef MUX_NX1_RR_ARB_EN
   // The pointer only moves when a round-robin pick is actually transferred.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && rr_mode) ptr_d = sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IDX_W'(NUM_INPUT - 1);
      else        ptr_q <= ptr_d;
   end
`endif

   assign o_valid    = valid_q;
   assign o_data_bus = data_q;

endmodule
